call_stack: RTL and testbench

- Return-address LIFO that sits at the other end of the decoder's stack interface.
- Consumes the decoder's stack_control {PUSH, POP} and produces stack_flags {FULL, EMPTY}.
- On CLL it stores the return address. On RET it presents the saved address to the PC mux and then discards it.
- Sits between the decoder and the program counter / jump logic.

---
 rtl/call_stack_pkg.sv | 23 ++
 rtl/call_stack_stack_mem.sv | 33 +++
 rtl/call_stack.sv | 127 ++++++++++++
 tb/tb_call_stack.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/call_stack_pkg.sv
//------------------------------------------------------------------------------
// call_stack_pkg : bit indices and operation encoding for the return-address stack
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

package call_stack_pkg;

  localparam int STK_PUSH  = 1;
  localparam int STK_POP   = 0;
  localparam int STK_FULL  = 1;
  localparam int STK_EMPTY = 0;

  typedef enum logic [1:0] {
    OP_HOLD    = 2'b00,
    OP_POP     = 2'b01,
    OP_PUSH    = 2'b10,
    OP_REPLACE = 2'b11
  } stack_op_e;

endpackage

`default_nettype wire

// File: rtl/call_stack_stack_mem.sv
//------------------------------------------------------------------------------
// stack_mem : DEPTH x ADDR_WIDTH register file, one sync write, one async read
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module stack_mem #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 8,
  parameter int IDX_WIDTH  = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [IDX_WIDTH-1:0]  i_waddr,
  input  logic [ADDR_WIDTH-1:0] i_wdata,
  input  logic [IDX_WIDTH-1:0]  i_raddr,
  output logic [ADDR_WIDTH-1:0] o_rdata
);

  logic [ADDR_WIDTH-1:0] r_mem [DEPTH];

  // Contents are qualified by the stack pointer, so no reset is needed here.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

`default_nettype wire

// File: rtl/call_stack.sv
//------------------------------------------------------------------------------
// call_stack : return-address LIFO between the decoder and the PC mux
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module call_stack
  import call_stack_pkg::*;
#(
  parameter  int ADDR_WIDTH = 8,
  parameter  int DEPTH      = 8,
  localparam int SP_WIDTH   = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            stack_control,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  output logic [1:0]            stack_flags,
  output logic [ADDR_WIDTH-1:0] top_addr,
  output logic [SP_WIDTH-1:0]   level,
  output logic                  overflow,
  output logic                  underflow,
  input  logic                  clr_err
);

  localparam int IDX_WIDTH = $clog2(DEPTH);

  logic [SP_WIDTH-1:0]   r_sp;
  logic                  r_overflow;
  logic                  r_underflow;

  stack_op_e             w_op;
  logic                  w_full;
  logic                  w_empty;
  logic [IDX_WIDTH-1:0]  w_top_idx;
  logic [ADDR_WIDTH-1:0] w_rdata;
  logic                  w_we;
  logic [IDX_WIDTH-1:0]  w_waddr;
  logic [SP_WIDTH-1:0]   w_sp_next;
  logic                  w_ovf_set;
  logic                  w_unf_set;

  assign w_op      = stack_op_e'({stack_control[STK_PUSH], stack_control[STK_POP]});
  assign w_full    = (r_sp == SP_WIDTH'(DEPTH));
  assign w_empty   = (r_sp == '0);
  assign w_top_idx = IDX_WIDTH'(r_sp - SP_WIDTH'(1));

  always_comb begin
    w_we      = 1'b0;
    w_waddr   = IDX_WIDTH'(r_sp);
    w_sp_next = r_sp;
    w_ovf_set = 1'b0;
    w_unf_set = 1'b0;
    case (w_op)
      OP_PUSH: begin
        if (!w_full) begin
          w_we      = 1'b1;
          w_sp_next = r_sp + SP_WIDTH'(1);
        end else begin
          w_ovf_set = 1'b1;
        end
      end
      OP_POP: begin
        if (!w_empty) begin
          w_sp_next = r_sp - SP_WIDTH'(1);
        end else begin
          w_unf_set = 1'b1;
        end
      end
      OP_REPLACE: begin
        // On an empty stack a replace degenerates to a plain push.
        w_we = 1'b1;
        if (w_empty) begin
          w_sp_next = SP_WIDTH'(1);
        end else begin
          w_waddr = w_top_idx;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp        <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_sp <= w_sp_next;
      // A new error event outranks a same-cycle clear.
      if (w_ovf_set) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  stack_mem #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_stack_mem (
    .clk     (clk),
    .i_we    (w_we & ~rst),
    .i_waddr (w_waddr),
    .i_wdata (push_addr),
    .i_raddr (w_top_idx),
    .o_rdata (w_rdata)
  );

  assign stack_flags[STK_FULL]  = w_full;
  assign stack_flags[STK_EMPTY] = w_empty;
  assign top_addr               = w_empty ? '0 : w_rdata;
  assign level                  = r_sp;
  assign overflow               = r_overflow;
  assign underflow              = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_call_stack.sv
//------------------------------------------------------------------------------
// tb_call_stack : vector table plus scoreboard bench for call_stack (DEPTH=4)
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_call_stack;

  logic       clk;
  logic       rst;
  logic [1:0] stack_control;
  logic [7:0] push_addr;
  logic [1:0] stack_flags;
  logic [7:0] top_addr;
  logic [2:0] level;
  logic       overflow;
  logic       underflow;
  logic       clr_err;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [1:0] ctl;
    logic [7:0] addr;
    logic       clr;
    logic       chk_pre;
    logic [7:0] pre_top;
    logic [2:0] lvl;
    logic [7:0] top;
    logic [1:0] flags;
    logic       ovf;
    logic       unf;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  call_stack #(
    .ADDR_WIDTH (8),
    .DEPTH      (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .stack_control (stack_control),
    .push_addr     (push_addr),
    .stack_flags   (stack_flags),
    .top_addr      (top_addr),
    .level         (level),
    .overflow      (overflow),
    .underflow     (underflow),
    .clr_err       (clr_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected end of test");
    $fatal(1, "timeout");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void add(input logic [1:0] ctl, input logic [7:0] addr, input logic clr,
                              input logic chk_pre, input logic [7:0] pre_top,
                              input logic [2:0] lvl, input logic [7:0] top,
                              input logic [1:0] flags, input logic ovf, input logic unf);
    vec_t v;
    v.ctl = ctl; v.addr = addr; v.clr = clr; v.chk_pre = chk_pre; v.pre_top = pre_top;
    v.lvl = lvl; v.top = top; v.flags = flags; v.ovf = ovf; v.unf = unf;
    vecs.push_back(v);
  endfunction

  task automatic check_state(input string tag, input logic [2:0] lvl, input logic [7:0] top,
                             input logic [1:0] flags, input logic ovf, input logic unf);
    chk({tag, ".level"},     32'(level),       32'(lvl));
    chk({tag, ".top_addr"},  32'(top_addr),    32'(top));
    chk({tag, ".flags"},     32'(stack_flags), 32'(flags));
    chk({tag, ".overflow"},  32'(overflow),    32'(ovf));
    chk({tag, ".underflow"}, 32'(underflow),   32'(unf));
  endtask

  // Drives one cycle of stimulus; expectation travels through the scoreboard.
  task automatic step(input vec_t v, input string tag);
    vec_t e;
    stack_control = v.ctl;
    push_addr     = v.addr;
    clr_err       = v.clr;
    sb.push_back(v);
    #1;
    if (v.chk_pre) chk({tag, ".pre_top"}, 32'(top_addr), 32'(v.pre_top));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk({tag, ".scoreboard_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check_state(tag, e.lvl, e.top, e.flags, e.ovf, e.unf);
    end
    stack_control = 2'b00;
    clr_err       = 1'b0;
  endtask

  task automatic op(input logic [1:0] ctl, input logic [7:0] addr, input logic clr,
                    input logic [2:0] lvl, input logic [7:0] top, input logic [1:0] flags,
                    input logic ovf, input logic unf, input string tag);
    vec_t v;
    v.ctl = ctl; v.addr = addr; v.clr = clr; v.chk_pre = 1'b0; v.pre_top = '0;
    v.lvl = lvl; v.top = top; v.flags = flags; v.ovf = ovf; v.unf = unf;
    step(v, tag);
  endtask

  initial begin
    rst           = 1'b1;
    stack_control = 2'b00;
    push_addr     = 8'h00;
    clr_err       = 1'b0;

    //   ctl    addr   clr pre pre_top lvl top    flags  ovf unf
    add(2'b00, 8'h00, 0, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 0);
    add(2'b00, 8'h00, 0, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 0);
    add(2'b00, 8'h00, 0, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 0);
    add(2'b10, 8'h11, 0, 0, 8'h00, 3'd1, 8'h11, 2'b00, 0, 0);
    add(2'b10, 8'h22, 0, 0, 8'h00, 3'd2, 8'h22, 2'b00, 0, 0);
    add(2'b10, 8'h33, 0, 0, 8'h00, 3'd3, 8'h33, 2'b00, 0, 0);
    add(2'b10, 8'h44, 0, 0, 8'h00, 3'd4, 8'h44, 2'b10, 0, 0);
    add(2'b10, 8'h55, 0, 0, 8'h00, 3'd4, 8'h44, 2'b10, 1, 0);
    add(2'b00, 8'h00, 1, 0, 8'h00, 3'd4, 8'h44, 2'b10, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h44, 3'd3, 8'h33, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h33, 3'd2, 8'h22, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h22, 3'd1, 8'h11, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h11, 3'd0, 8'h00, 2'b01, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h00, 3'd0, 8'h00, 2'b01, 0, 1);
    add(2'b00, 8'h00, 1, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 0);
    // nested call/ret
    add(2'b10, 8'h0A, 0, 0, 8'h00, 3'd1, 8'h0A, 2'b00, 0, 0);
    add(2'b10, 8'h0B, 0, 0, 8'h00, 3'd2, 8'h0B, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h0B, 3'd1, 8'h0A, 2'b00, 0, 0);
    add(2'b10, 8'h0C, 0, 0, 8'h00, 3'd2, 8'h0C, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h0C, 3'd1, 8'h0A, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h0A, 3'd0, 8'h00, 2'b01, 0, 0);
    // replace-top: empty behaves as push, non-empty overwrites
    add(2'b11, 8'h99, 0, 0, 8'h00, 3'd1, 8'h99, 2'b00, 0, 0);
    add(2'b10, 8'h22, 0, 0, 8'h00, 3'd2, 8'h22, 2'b00, 0, 0);
    add(2'b11, 8'h99, 0, 1, 8'h22, 3'd2, 8'h99, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h99, 3'd1, 8'h99, 2'b00, 0, 0);
    add(2'b01, 8'h00, 0, 1, 8'h99, 3'd0, 8'h00, 2'b01, 0, 0);
    // error set beats a same-cycle clear
    add(2'b01, 8'h00, 0, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 1);
    add(2'b01, 8'h00, 1, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 1);
    add(2'b00, 8'h00, 1, 0, 8'h00, 3'd0, 8'h00, 2'b01, 0, 0);

    #12;
    rst = 1'b0;
    #1;
    check_state("reset", 3'd0, 8'h00, 2'b01, 1'b0, 1'b0);
    @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], $sformatf("vec%0d", i));
    end

    // Asynchronous reset in the middle of a cycle while a push is pending.
    op(2'b10, 8'hA1, 0, 3'd1, 8'hA1, 2'b00, 0, 0, "ar_push1");
    op(2'b10, 8'hA2, 0, 3'd2, 8'hA2, 2'b00, 0, 0, "ar_push2");
    op(2'b10, 8'hA3, 0, 3'd3, 8'hA3, 2'b00, 0, 0, "ar_push3");
    stack_control = 2'b10;
    push_addr     = 8'hA4;
    #2;
    rst = 1'b1;
    #1;
    check_state("async_rst", 3'd0, 8'h00, 2'b01, 1'b0, 1'b0);
    stack_control = 2'b00;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_state("post_rst", 3'd0, 8'h00, 2'b01, 1'b0, 1'b0);

    // Induced overflow, then clear.
    op(2'b10, 8'hB1, 0, 3'd1, 8'hB1, 2'b00, 0, 0, "ov_push1");
    op(2'b10, 8'hB2, 0, 3'd2, 8'hB2, 2'b00, 0, 0, "ov_push2");
    op(2'b10, 8'hB3, 0, 3'd3, 8'hB3, 2'b00, 0, 0, "ov_push3");
    op(2'b10, 8'hB4, 0, 3'd4, 8'hB4, 2'b10, 0, 0, "ov_push4");
    op(2'b10, 8'hB5, 0, 3'd4, 8'hB4, 2'b10, 1, 0, "ov_push5");
    op(2'b00, 8'h00, 0, 3'd4, 8'hB4, 2'b10, 1, 0, "ov_sticky");
    op(2'b00, 8'h00, 1, 3'd4, 8'hB4, 2'b10, 0, 0, "ov_clear");

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
